// File: rtl/mpm_port_driver.sv
// mpm_port_driver: request-side front end for the multi-port memory.
// Each port has an issue register driving addr/en/d, a read-valid shift
// register matched to the memory read latency, a read credit counter and a
// first-word-fall-through response FIFO fed from q.
// Build option: define MPM_CONFLICT_CHECK_EN to stall higher-index ports that
// write the same address as a lower-index port in the same cycle.
module mpm_port_driver #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter int PORTS        = 4,
  parameter int READ_LATENCY = 1,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid [PORTS-1:0],
  output logic                     req_ready [PORTS-1:0],
  input  logic                     req_write [PORTS-1:0],
  input  logic [$clog2(DEPTH)-1:0] req_addr  [PORTS-1:0],
  input  logic [WIDTH-1:0]         req_data  [PORTS-1:0],
  output logic                     rsp_valid [PORTS-1:0],
  input  logic                     rsp_ready [PORTS-1:0],
  output logic [WIDTH-1:0]         rsp_data  [PORTS-1:0],
  output logic [$clog2(DEPTH)-1:0] addr      [PORTS-1:0],
  output logic                     en        [PORTS-1:0],
  output logic [WIDTH-1:0]         d         [PORTS-1:0],
  input  logic [WIDTH-1:0]         q         [PORTS-1:0]
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RSP_DEPTH - 1);

  logic                    conflict [PORTS];
  logic                    acc_rd   [PORTS];
  logic                    acc_wr   [PORTS];
  logic                    push     [PORTS];
  logic                    pop      [PORTS];
  logic                    rd_issue [PORTS];
  logic [READ_LATENCY-1:0] rd_pipe  [PORTS];
  logic [CW-1:0]           cnt      [PORTS];
  logic [CW-1:0]           fifo_cnt [PORTS];
  logic [PW-1:0]           wr_ptr   [PORTS];
  logic [PW-1:0]           rd_ptr   [PORTS];
  logic [WIDTH-1:0]        fifo_mem [PORTS][RSP_DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  endfunction

  // Conflict resolution, credit gating, acceptance and FIFO read side.
  // Credits count reads from acceptance until pop, so a push never meets a
  // full FIFO; rsp_ready deliberately does not feed req_ready.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      conflict[p] = 1'b0;
`ifdef MPM_CONFLICT_CHECK_EN
      for (int j = 0; j < p; j++) begin
        if (req_write[p] && req_valid[j] && req_write[j] &&
            (req_addr[j] == req_addr[p]))
          conflict[p] = 1'b1;
      end
`endif
      req_ready[p] = !rst && !(!req_write[p] && (cnt[p] == CREDIT_MAX)) && !conflict[p];
      acc_rd[p]    = req_valid[p] && req_ready[p] && !req_write[p];
      acc_wr[p]    = req_valid[p] && req_ready[p] && req_write[p];
      push[p]      = rd_pipe[p][READ_LATENCY-1];
      rsp_valid[p] = (fifo_cnt[p] != '0);
      rsp_data[p]  = fifo_mem[p][rd_ptr[p]];
      pop[p]       = rsp_valid[p] && rsp_ready[p];
    end
  end

  // Issue registers, read tracking, credits and FIFO occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PORTS; p++) begin
        addr[p]     <= '0;
        en[p]       <= 1'b0;
        d[p]        <= '0;
        rd_issue[p] <= 1'b0;
        rd_pipe[p]  <= '0;
        cnt[p]      <= '0;
        fifo_cnt[p] <= '0;
        wr_ptr[p]   <= '0;
        rd_ptr[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        en[p]       <= acc_wr[p];
        rd_issue[p] <= acc_rd[p];
        if (acc_rd[p] || acc_wr[p]) begin
          addr[p] <= req_addr[p];
          d[p]    <= req_data[p];
        end
        rd_pipe[p][0] <= rd_issue[p];
        for (int i = 1; i < READ_LATENCY; i++)
          rd_pipe[p][i] <= rd_pipe[p][i-1];
        case ({acc_rd[p], pop[p]})
          2'b10:   cnt[p] <= cnt[p] + CW'(1);
          2'b01:   cnt[p] <= cnt[p] - CW'(1);
          default: ;
        endcase
        case ({push[p], pop[p]})
          2'b10:   fifo_cnt[p] <= fifo_cnt[p] + CW'(1);
          2'b01:   fifo_cnt[p] <= fifo_cnt[p] - CW'(1);
          default: ;
        endcase
        if (push[p]) wr_ptr[p] <= next_ptr(wr_ptr[p]);
        if (pop[p])  rd_ptr[p] <= next_ptr(rd_ptr[p]);
      end
    end
  end

  // Response storage; q is captured when the tracked read reaches the tail.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (!rst && push[p])
        fifo_mem[p][wr_ptr[p]] <= q[p];
    end
  end

endmodule

// File: tb/tb_mpm_port_driver.sv
// Directed bench for mpm_port_driver with a behavioural memory on the
// addr/en/d/q side and a per-port scoreboard of expected read data.
module tb_mpm_port_driver;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int PORTS = 4;
  localparam int RL    = 1;
  localparam int RSPD  = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst;
  logic             mem_clr;
  logic             req_valid [PORTS-1:0];
  logic             req_ready [PORTS-1:0];
  logic             req_write [PORTS-1:0];
  logic [AW-1:0]    req_addr  [PORTS-1:0];
  logic [WIDTH-1:0] req_data  [PORTS-1:0];
  logic             rsp_valid [PORTS-1:0];
  logic             rsp_ready [PORTS-1:0];
  logic [WIDTH-1:0] rsp_data  [PORTS-1:0];
  logic [AW-1:0]    addr      [PORTS-1:0];
  logic             en        [PORTS-1:0];
  logic [WIDTH-1:0] d         [PORTS-1:0];
  logic [WIDTH-1:0] q         [PORTS-1:0];

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q   [PORTS][$];
  logic [AW-1:0]    rd_a;
  logic [WIDTH-1:0] rd_v;

  int vectors;
  int miscompares;

  mpm_port_driver #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS),
    .READ_LATENCY(RL), .RSP_DEPTH(RSPD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .addr(addr), .en(en), .d(d), .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: q registered from the pre-write contents (READ_LATENCY 1).
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int p = 0; p < PORTS; p++) q[p] <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        q[p] <= mem[addr[p]];
        if (en[p]) mem[addr[p]] <= d[p];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < PORTS; p++) begin
      req_valid[p] = 1'b0;
      req_write[p] = 1'b0;
    end
  endtask

  // One clock: score responses popped and requests accepted in this cycle,
  // then advance to the next falling edge.
  task automatic step();
    logic [WIDTH-1:0] e;
    #1;
    for (int p = 0; p < PORTS; p++) begin
      if (rsp_valid[p] && rsp_ready[p]) begin
        vectors++;
        assert (exp_q[p].size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_rsp p%0d: observed data %0h expected no response", p, rsp_data[p]);
        end
        if (exp_q[p].size() != 0) begin
          e = exp_q[p].pop_front();
          chk($sformatf("rsp_data_p%0d", p), rsp_data[p], e);
        end
      end
    end
    for (int p = 0; p < PORTS; p++)
      if (req_valid[p] && req_ready[p] && !req_write[p])
        exp_q[p].push_back(ref_mem[req_addr[p]]);
    for (int p = 0; p < PORTS; p++)
      if (req_valid[p] && req_ready[p] && req_write[p])
        ref_mem[req_addr[p]] = req_data[p];
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rst = 1'b1;
    mem_clr = 1'b1;
    for (int p = 0; p < PORTS; p++) begin
      req_valid[p] = 1'b0; req_write[p] = 1'b0;
      req_addr[p] = '0; req_data[p] = '0; rsp_ready[p] = 1'b1;
    end
    @(negedge clk);
    step();
    step();

    // Reset state: nothing accepted even with requests pending.
    for (int p = 0; p < PORTS; p++) req_valid[p] = 1'b1;
    #1;
    for (int p = 0; p < PORTS; p++) begin
      chk($sformatf("rst_ready_p%0d", p), req_ready[p], 0);
      chk($sformatf("rst_en_p%0d", p), en[p], 0);
      chk($sformatf("rst_addr_p%0d", p), addr[p], 0);
      chk($sformatf("rst_d_p%0d", p), d[p], 0);
      chk($sformatf("rst_rsp_valid_p%0d", p), rsp_valid[p], 0);
    end
    idle_inputs();
    rst = 1'b0;
    mem_clr = 1'b0;
    step();

    // Write then read back on port 0; response three cycles after accept.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'd5; req_data[0] = 32'hDEADBEEF;
    #1 chk("t1_wr_ready", req_ready[0], 1);
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("t1_wr_en", en[0], 1);
    chk("t1_wr_addr", addr[0], 5);
    chk("t1_wr_d", d[0], 32'hDEADBEEF);
    req_valid[0] = 1'b1; req_write[0] = 1'b0;
    #1 chk("t1_rd_ready", req_ready[0], 1);
    step();
    idle_inputs();
    #1;
    chk("t1_rd_en", en[0], 0);
    chk("t1_rd_addr", addr[0], 5);
    chk("t1_lat1", rsp_valid[0], 0);
    step();
    #1 chk("t1_lat2", rsp_valid[0], 0);
    step();
    #1;
    chk("t1_lat3", rsp_valid[0], 1);
    chk("t1_data", rsp_data[0], 32'hDEADBEEF);
    step();
    #1 chk("t1_popped", rsp_valid[0], 0);

    // Same-cycle read and write of one address: read sees the old value.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'd9; req_data[0] = 32'h55;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 10'd9;
    #1;
    chk("t6_ready0", req_ready[0], 1);
    chk("t6_ready1", req_ready[1], 1);
    step();
    idle_inputs();
    step();
    step();
    #1;
    chk("t6_rsp_valid", rsp_valid[1], 1);
    chk("t6_old_data", rsp_data[1], 32'h0);
    step();
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 10'd9;
    step();
    idle_inputs();
    step();
    step();
    #1 chk("t6_new_data", rsp_data[1], 32'h55);
    step();

    // Write-write on ports 0 and 2.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'd7; req_data[0] = 32'h11;
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_data[2] = 32'h22;
`ifdef MPM_CONFLICT_CHECK_EN
    rd_a = 10'd7;
    req_addr[2] = 10'd7;
    #1;
    chk("t2_ready0", req_ready[0], 1);
    chk("t2_ready2_stall", req_ready[2], 0);
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("t2_en0", en[0], 1);
    chk("t2_en2_held", en[2], 0);
    chk("t2_ready2_retry", req_ready[2], 1);
    step();
    idle_inputs();
    #1 chk("t2_en2", en[2], 1);
`else
    rd_a = 10'd8;
    req_addr[2] = 10'd8;
    #1;
    chk("t2_ready0", req_ready[0], 1);
    chk("t2_ready2", req_ready[2], 1);
    step();
    idle_inputs();
    #1 chk("t2_en2", en[2], 1);
`endif
    step();
    rd_v = 32'h22;
    req_valid[3] = 1'b1; req_write[3] = 1'b0; req_addr[3] = rd_a;
    step();
    idle_inputs();
    step();
    step();
    #1;
    chk("t2_rsp_valid", rsp_valid[3], 1);
    chk("t2_winner_data", rsp_data[3], rd_v);
    step();

    // Credit limit on port 1 with the consumer stalled.
    for (int p = 0; p < PORTS; p++) begin
      req_valid[p] = 1'b1; req_write[p] = 1'b1;
      req_addr[p] = AW'(100 + p); req_data[p] = 32'hA0 + p;
    end
    step();
    idle_inputs();
    step();
    rsp_ready[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = AW'(100 + (i % 4));
      #1 chk($sformatf("t3_ready_c%0d", i), req_ready[1], (i < 4) ? 1 : 0);
      step();
    end
    idle_inputs();
    #1 chk("t3_held", rsp_valid[1], 1);
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("t3_drain_c%0d", i), rsp_valid[1], 1);
      step();
    end
    #1 chk("t3_empty", rsp_valid[1], 0);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 10'd101;
    #1 chk("t3_resume", req_ready[1], 1);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Every port reads every cycle with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < PORTS; p++) begin
        req_valid[p] = 1'b1; req_write[p] = 1'b0; req_addr[p] = AW'(100 + ((p + i) % 4));
      end
      #1;
      for (int p = 0; p < PORTS; p++) begin
        chk($sformatf("t4_ready_p%0d_c%0d", p, i), req_ready[p], 1);
        if (i >= 3) chk($sformatf("t4_rsp_p%0d_c%0d", p, i), rsp_valid[p], 1);
      end
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Reset with two reads in flight and one waiting in the FIFO.
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = AW'(100 + i);
      step();
    end
    idle_inputs();
    #1 chk("t5_pre_fifo", rsp_valid[0], 1);
    rst = 1'b1;
    step();
    req_valid[0] = 1'b1;
    #1;
    chk("t5_rsp_valid", rsp_valid[0], 0);
    chk("t5_en", en[0], 0);
    chk("t5_ready_in_rst", req_ready[0], 0);
    for (int p = 0; p < PORTS; p++) exp_q[p].delete();
    idle_inputs();
    rst = 1'b0;
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("t5_no_stale_c%0d", i), rsp_valid[0], 0);
      step();
    end
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = AW'(100 + (i % 4));
      #1 chk($sformatf("t5_credit_c%0d", i), req_ready[0], (i < 4) ? 1 : 0);
      step();
    end
    idle_inputs();
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) step();

    for (int p = 0; p < PORTS; p++)
      chk($sformatf("leftover_p%0d", p), exp_q[p].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
